// File: rtl/solver_dispatch.sv
// Job feeder for the solver load port: takes a header and c limbs, programs the solver,
// pulses start and returns the iteration count. Define DISPATCH_CYCLE_COUNT_EN for res_cycles.
module solver_dispatch #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32,
    parameter int TAG_BITS        = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [LIMB_INDEX_BITS-1:0] job_num_limbs,
    input  logic [15:0]                job_iter_lim,
    input  logic [TAG_BITS-1:0]        job_tag,
    input  logic                       limb_valid,
    output logic                       limb_ready,
    input  logic [LIMB_BITS-1:0]       limb_data,
    output logic                       wr_real_en,
    output logic                       wr_imag_en,
    output logic [LIMB_INDEX_BITS-1:0] wr_ind,
    output logic [LIMB_BITS-1:0]       c_data,
    output logic                       wr_num_limbs_en,
    output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
    output logic                       wr_iter_lim_en,
    output logic [15:0]                iter_lim_data,
    output logic                       start,
    input  logic                       out_ready,
    input  logic [15:0]                iteration_count,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [15:0]                res_count,
    output logic [TAG_BITS-1:0]        res_tag,
`ifdef DISPATCH_CYCLE_COUNT_EN
    output logic [31:0]                res_cycles,
`endif
    output logic                       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_LOAD_RE, S_LOAD_IM, S_START, S_RUN, S_RESULT
    } state_t;

    state_t                     state_q;
    logic [LIMB_INDEX_BITS-1:0] n_q, cnt_q;
    logic [15:0]                lim_q;
    logic [TAG_BITS-1:0]        tag_q;
    logic                       res_valid_q;
    logic [15:0]                res_count_q;
    logic [TAG_BITS-1:0]        res_tag_q;
    logic                       last_limb;

    assign last_limb       = (cnt_q == n_q - LIMB_INDEX_BITS'(1));
    assign job_ready       = (state_q == S_IDLE);
    assign limb_ready      = (state_q == S_LOAD_RE) || (state_q == S_LOAD_IM);
    assign wr_real_en      = (state_q == S_LOAD_RE) && limb_valid;
    assign wr_imag_en      = (state_q == S_LOAD_IM) && limb_valid;
    assign wr_ind          = cnt_q;
    assign c_data          = limb_data;
    assign wr_num_limbs_en = (state_q == S_CFG);
    assign wr_iter_lim_en  = (state_q == S_CFG);
    assign num_limbs_data  = n_q;
    assign iter_lim_data   = lim_q;
    assign start           = (state_q == S_START);
    assign busy            = (state_q != S_IDLE);
    assign res_valid       = res_valid_q;
    assign res_count       = res_count_q;
    assign res_tag         = res_tag_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            lim_q       <= '0;
            tag_q       <= '0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
            res_tag_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (job_valid) begin
                    // A zero count or limit would make the solver spin on nothing
                    n_q     <= (job_num_limbs == '0) ? LIMB_INDEX_BITS'(1) : job_num_limbs;
                    lim_q   <= (job_iter_lim == '0) ? 16'd1 : job_iter_lim;
                    tag_q   <= job_tag;
                    state_q <= S_CFG;
                end
                S_CFG: begin
                    cnt_q   <= '0;
                    state_q <= S_LOAD_RE;
                end
                S_LOAD_RE: if (limb_valid) begin
                    cnt_q <= last_limb ? '0 : cnt_q + LIMB_INDEX_BITS'(1);
                    if (last_limb) state_q <= S_LOAD_IM;
                end
                S_LOAD_IM: if (limb_valid) begin
                    cnt_q <= last_limb ? '0 : cnt_q + LIMB_INDEX_BITS'(1);
                    if (last_limb) state_q <= S_START;
                end
                // out_ready still reflects the previous solve here; the solver drops it on this edge
                S_START: state_q <= S_RUN;
                S_RUN: if (out_ready) begin
                    res_count_q <= iteration_count;
                    res_tag_q   <= tag_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_RESULT;
                end
                S_RESULT: if (res_ready) begin
                    res_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DISPATCH_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_inc, res_cycles_q;

    assign cyc_inc    = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
    assign res_cycles = res_cycles_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_q        <= '0;
            res_cycles_q <= '0;
        end else begin
            if (state_q == S_LOAD_IM && limb_valid && last_limb)
                cyc_q <= '0;
            else if (state_q == S_START || state_q == S_RUN)
                cyc_q <= cyc_inc;
            // Captured value includes the cycle on which out_ready is seen
            if (state_q == S_RUN && out_ready)
                res_cycles_q <= cyc_inc;
        end
    end
`endif

endmodule

// File: tb/tb_solver_dispatch.sv
// Scoreboard bench for solver_dispatch: directed jobs push expected solver-port events,
// a negedge monitor pops and compares them.
module tb_solver_dispatch;
    localparam int LIB = 6;
    localparam int LB  = 32;
    localparam int TB  = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           job_valid = 1'b0, job_ready;
    logic [LIB-1:0] job_num_limbs = '0;
    logic [15:0]    job_iter_lim = '0;
    logic [TB-1:0]  job_tag = '0;
    logic           limb_valid = 1'b0, limb_ready;
    logic [LB-1:0]  limb_data = '0;
    logic           wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en, start, busy;
    logic [LIB-1:0] wr_ind, num_limbs_data;
    logic [LB-1:0]  c_data;
    logic [15:0]    iter_lim_data, res_count;
    logic           out_ready = 1'b0;
    logic [15:0]    iteration_count = '0;
    logic           res_valid, res_ready = 1'b0;
    logic [TB-1:0]  res_tag;
`ifdef DISPATCH_CYCLE_COUNT_EN
    logic [31:0]    res_cycles;
`endif

    solver_dispatch #(.LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .TAG_BITS(TB)) dut (
        .clock(clock), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_num_limbs(job_num_limbs),
        .job_iter_lim(job_iter_lim), .job_tag(job_tag),
        .limb_valid(limb_valid), .limb_ready(limb_ready), .limb_data(limb_data),
        .wr_real_en(wr_real_en), .wr_imag_en(wr_imag_en), .wr_ind(wr_ind), .c_data(c_data),
        .wr_num_limbs_en(wr_num_limbs_en), .num_limbs_data(num_limbs_data),
        .wr_iter_lim_en(wr_iter_lim_en), .iter_lim_data(iter_lim_data),
        .start(start), .out_ready(out_ready), .iteration_count(iteration_count),
        .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count), .res_tag(res_tag),
`ifdef DISPATCH_CYCLE_COUNT_EN
        .res_cycles(res_cycles),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    // kind: 0 cfg(a=n,b=lim) 1 real(a=ind,b=data) 2 imag 3 start 4 result(a=count,b=tag,c=cycles)
    typedef struct {
        int          kind;
        logic [31:0] a, b, c;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mon_step();
        int          k, nev;
        logic [31:0] a, b, c;
        exp_t        e;
        k = -1; nev = 0; a = '0; b = '0; c = '0;
        if (wr_num_limbs_en || wr_iter_lim_en) begin
            chk("cfg_pair", 32'(wr_num_limbs_en), 32'(wr_iter_lim_en));
            k = 0; nev++; a = 32'(num_limbs_data); b = 32'(iter_lim_data);
        end
        if (wr_real_en) begin k = 1; nev++; a = 32'(wr_ind); b = c_data; end
        if (wr_imag_en) begin k = 2; nev++; a = 32'(wr_ind); b = c_data; end
        if (start) begin k = 3; nev++; end
        if (res_valid && res_ready) begin
            k = 4; nev++; a = 32'(res_count); b = 32'(res_tag);
`ifdef DISPATCH_CYCLE_COUNT_EN
            c = res_cycles;
`endif
        end
        if (nev > 1) begin
            n_tests++; n_fail++;
            $display("FAIL ev_overlap: got %0d events in one cycle expected 1 at %0t", nev, $time);
        end else if (k >= 0) begin
            if (sbq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL ev_unexpected: got event kind %0d expected none at %0t", k, $time);
            end else begin
                e = sbq.pop_front();
                chk("ev_kind", 32'(k), 32'(e.kind));
                chk("ev_a", a, e.a);
                chk("ev_b", b, e.b);
`ifdef DISPATCH_CYCLE_COUNT_EN
                chk("ev_cycles", c, e.c);
`endif
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) mon_step();
        end
    end

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_job_ready", 32'(job_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr", {29'd0, wr_real_en, wr_imag_en, wr_num_limbs_en}, 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_limb_ready", 32'(limb_ready), 0);
        sbq.delete();
        job_valid = 1'b0; limb_valid = 1'b0; out_ready = 1'b0; res_ready = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("post_rst_idle", 32'(job_ready), 1);
    endtask

    // abort: 0 complete, 1 reset during LOAD_IM, 2 reset during RUN
    task automatic job(input int n, input int lim, input int tag, input int gap,
                       input int wait_c, input int iters, input int abort);
        int   ne, le, t;
        exp_t e;
        ne = (n == 0) ? 1 : n;
        le = (lim == 0) ? 1 : lim;
        e = '{0, 32'(ne), 32'(le), 0}; sbq.push_back(e);
        for (int i = 0; i < 2 * ne; i++) begin
            e = '{(i < ne) ? 1 : 2, 32'(i % ne), 32'(tag * 65536 + 16 + i), 0};
            sbq.push_back(e);
        end
        e = '{3, 0, 0, 0}; sbq.push_back(e);
        e = '{4, 32'(iters), 32'(tag), 32'(wait_c + 1)}; sbq.push_back(e);

        @(posedge clock); #1;
        job_valid = 1'b1; job_num_limbs = LIB'(n); job_iter_lim = 16'(lim); job_tag = TB'(tag);
        t = 0;
        @(negedge clock);
        while (!job_ready && t < 50) begin @(negedge clock); t++; end
        if (!job_ready) chk("hdr_timeout", 32'(job_ready), 1);
        @(posedge clock); #1 job_valid = 1'b0;

        for (int i = 0; i < 2 * ne; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    limb_valid = 1'b0;
                    @(negedge clock);
                    chk("gap_ready", 32'(limb_ready), 1);
                    @(posedge clock); #1;
                end
            end
            limb_valid = 1'b1; limb_data = LB'(tag * 65536 + 16 + i);
            if (abort == 1 && i == ne + 1) begin
                do_reset();
                return;
            end
            t = 0;
            @(negedge clock);
            while (!limb_ready && t < 50) begin @(negedge clock); t++; end
            if (!limb_ready) chk("limb_timeout", 32'(limb_ready), 1);
            @(posedge clock); #1 limb_valid = 1'b0;
        end

        @(negedge clock);
        chk("start_after_last", 32'(start), 1);
        @(posedge clock); #1 out_ready = 1'b0;
        if (abort == 2) begin
            repeat (5) @(posedge clock);
            #1 do_reset();
            repeat (3) begin
                @(negedge clock);
                chk("no_res_after_rst", 32'(res_valid), 0);
            end
            return;
        end
        repeat (wait_c - 1) @(posedge clock);
        #1 out_ready = 1'b1; iteration_count = 16'(iters);
        @(posedge clock);
        repeat (5) begin
            @(negedge clock);
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_count", 32'(res_count), 32'(iters));
            chk("hold_tag", 32'(res_tag), 32'(tag));
            chk("hold_job_ready", 32'(job_ready), 0);
            chk("hold_num_limbs", 32'(num_limbs_data), 32'(ne));
        end
        @(posedge clock); #1 res_ready = 1'b1;
        @(posedge clock); #1 res_ready = 1'b0;
        @(negedge clock);
        chk("idle_job_ready", 32'(job_ready), 1);
        chk("idle_res_valid", 32'(res_valid), 0);
    endtask

    initial begin
        #12;
        chk("reset_job_ready", 32'(job_ready), 1);
        chk("reset_res_valid", 32'(res_valid), 0);
        chk("reset_start", 32'(start), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_num_limbs", 32'(num_limbs_data), 0);
        @(posedge clock); #1 reset = 1'b0;

        job(2, 100, 'h5A, 0, 50, 37, 0);
        job(0, 0, 'h11, 0, 20, 5, 0);
        job(3, 7, 'h22, 2, 3, 9, 0);
        job(2, 10, 'h33, 0, 10, 1, 1);
        job(2, 10, 'h44, 0, 10, 4, 0);
        job(1, 5, 'h55, 0, 10, 2, 2);
        job(2, 8, 'h66, 1, 4, 3, 0);

        repeat (3) @(posedge clock);
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
